bram_port_requester: RTL and testbench
======================================

// Module: bram_port_requester
// PURPOSE
// - Initiator for one port of the BRAM2 dual-port RAM (ADDR/DI/EN/WE/DO). Turns a
//   valid/ready request stream into BRAM port cycles, and the fixed-latency read data
//   into a valid/ready response stream.
// - Read data is captured exactly at BRAM latency. It is buffered in a credit-limited
//   FIFO, so a stalled consumer never loses data.
// - Sits between packet-processing logic and either BRAM2 port, one instance per port.
// PARAMETERS
// - PIPELINED   0   must match the attached BRAM2; read latency L = 1 + PIPELINED
// - ADDR_WIDTH  1   address width
// - DATA_WIDTH  1   data width
// - RSP_DEPTH   4   response FIFO entries; legal minimum 1; full read throughput needs >= L+2
// PORTS
// - CLK         in   1           clock; all logic on posedge
// - RST_N       in   1           synchronous reset, active-low
// - req_valid   in   1           request present
// - req_ready   out  1           request accepted when req_valid && req_ready
// - req_we      in   1           1 = write, 0 = read
// - req_addr    in   ADDR_WIDTH  request address
// - req_wdata   in   DATA_WIDTH  write data (ignored for reads)
// - rsp_valid   out  1           read response available
// - rsp_ready   in   1           consumer takes response when rsp_valid && rsp_ready
// - rsp_rdata   out  DATA_WIDTH  read data, in request order
// - bram_en     out  1           to BRAM ENx
// - bram_we     out  1           to BRAM WEx
// - bram_addr   out  ADDR_WIDTH  to BRAM ADDRx
// - bram_wdata  out  DATA_WIDTH  to BRAM DIx
// - bram_rdata  in   DATA_WIDTH  from BRAM DOx
// - rd_pending  out  $clog2(RSP_DEPTH+1)  reads accepted but not yet popped
// - idle        out  1           rd_pending == 0
// BEHAVIOUR
// - Reset (RST_N=0 at posedge):
//   - in-flight shift register, FIFO pointers and rd_pending cleared
//   - rsp_valid=0, rd_pending=0, idle=1, rsp_rdata=0
//   - bram_en=0 while RST_N=0; req_ready=0 while RST_N=0
// - req_ready = (rd_pending < RSP_DEPTH). Registered count; combinational compare.
//   - No dependence on req_valid or req_we; writes are gated by credit too.
// - Accept = req_valid && req_ready. Port signals are a combinational pass-through:
//   - bram_en = accept, bram_we = req_we, bram_addr = req_addr, bram_wdata = req_wdata
//   - Zero added latency on the BRAM side.
// - Write: no response, no credit consumed, no FIFO entry.
// - Read: rd_pending += 1 at the accept edge. A 1 is shifted into an L-stage valid pipe.
// - Capture: when the pipe's last stage is 1, bram_rdata is written into the FIFO tail
//   at that posedge. For a read accepted in cycle t, data is sampled at end of cycle t+L.
//   - bram_rdata is never sampled at any other time.
//   - BRAM holds stale DO between reads, and its pipelined output moves every cycle.
// - rsp_valid = FIFO non-empty; rsp_rdata = head entry.
//   - Response first visible in cycle t+L+1, so request-to-response latency is L+1.
// - Pop = rsp_valid && rsp_ready: rd_pending -= 1 and head advances.
//   - Simultaneous read accept and pop: rd_pending unchanged.
//   - Simultaneous capture and pop: both happen, occupancy unchanged.
// - Overflow is impossible by construction: FIFO occupancy + in-flight <= rd_pending <= RSP_DEPTH.
//   - Assertions: no capture into a full FIFO; rd_pending never exceeds RSP_DEPTH or underflows.
// - FIFO pointers wrap modulo RSP_DEPTH. RSP_DEPTH need not be a power of 2.
// - rsp_valid/rsp_rdata hold stable while rsp_valid && !rsp_ready.
// - Reset mid-operation: in-flight reads are discarded. Any late BRAM data is ignored
//   because the pipe is cleared. No response after reset until a new read is accepted.
// - Read-after-write to the same address in consecutive cycles returns the new data,
//   because the BRAM updates at the write edge.
// TESTING
// - PIPELINED=0: write 0x5A to addr 3, then read addr 3
//   -> bram_en on both; rsp_valid 2 cycles after read accept; rsp_rdata=0x5A.
// - PIPELINED=1, RSP_DEPTH=4, rsp_ready=1: reads to addrs 0..7 back-to-back
//   -> req_ready stays 1; 8 responses on consecutive cycles, in address order;
//      first response 3 cycles after first accept.
// - rsp_ready=0, RSP_DEPTH=4: issue 6 reads
//   -> exactly 4 accepted, req_ready=0, rd_pending=4, head data stable;
//      raise rsp_ready -> all 4 drain in order, then remaining 2 accepted.
// - Stale-data check: read addr 1 (=0x11), idle 5 cycles while bram_rdata holds 0x11
//   -> exactly one response, no duplicates.
// - Accept and pop in the same cycle with FIFO holding 1 entry
//   -> rd_pending unchanged, order preserved.
// - Reset asserted 1 cycle after a PIPELINED=1 read accept
//   -> rsp_valid=0 and idle=1 after reset, no response ever emitted for that read.

Source files
------------

// File: rtl/bram_port_requester.sv
// Drives one BRAM2 port from a valid/ready request stream and returns read data
// through a credit-limited response FIFO, so a stalled consumer never loses data.
module bram_port_requester #(
  parameter int PIPELINED  = 0,
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_we,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  input  logic [DATA_WIDTH-1:0]          req_wdata,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           bram_en,
  output logic                           bram_we,
  output logic [ADDR_WIDTH-1:0]          bram_addr,
  output logic [DATA_WIDTH-1:0]          bram_wdata,
  input  logic [DATA_WIDTH-1:0]          bram_rdata,
  output logic [$clog2(RSP_DEPTH+1)-1:0] rd_pending,
  output logic                           idle
);

  localparam int LAT = 1 + PIPELINED;
  localparam int CW  = $clog2(RSP_DEPTH + 1);
  localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(RSP_DEPTH - 1);

  logic                  accept;
  logic                  rd_accept;
  logic                  capture;
  logic                  pop;
  logic [LAT-1:0]        rd_pipe;
  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         fifo_count;

  // Credit covers every read from accept until its response is popped.
  assign req_ready = RST_N && (rd_pending < CW'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_we;
  assign capture   = rd_pipe[LAT-1];
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_rdata = rsp_valid ? fifo_mem[head] : '0;
  assign idle      = (rd_pending == '0);

  assign bram_en    = accept;
  assign bram_we    = req_we;
  assign bram_addr  = req_addr;
  assign bram_wdata = req_wdata;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rd_pipe    <= '0;
      head       <= '0;
      tail       <= '0;
      fifo_count <= '0;
      rd_pending <= '0;
    end else begin
      rd_pipe <= (rd_pipe << 1) | LAT'(rd_accept);
      if (capture)
        tail <= (tail == LAST_IDX) ? '0 : tail + 1'b1;
      if (pop)
        head <= (head == LAST_IDX) ? '0 : head + 1'b1;
      case ({capture, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      case ({rd_accept, pop})
        2'b10:   rd_pending <= rd_pending + 1'b1;
        2'b01:   rd_pending <= rd_pending - 1'b1;
        default: rd_pending <= rd_pending;
      endcase
    end
  end

  // BRAM output is only trusted on the exact latency cycle of a live read.
  always_ff @(posedge CLK) begin
    if (RST_N && capture)
      fifo_mem[tail] <= bram_rdata;
  end

  a_no_full_capture: assert property (@(posedge CLK) disable iff (!RST_N)
    capture |-> (fifo_count < CW'(RSP_DEPTH)));
  a_pending_bound: assert property (@(posedge CLK) disable iff (!RST_N)
    rd_pending <= CW'(RSP_DEPTH));
  a_no_underflow: assert property (@(posedge CLK) disable iff (!RST_N)
    pop |-> (rd_pending != '0));

endmodule

// File: tb/tb_bram_port_requester.sv
// Drives a non-pipelined and a pipelined requester with shared stimulus, each on its
// own BRAM2 model, and compares them against a timestamped in-order response model.
module tb_bram_port_requester;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       req_valid;
  logic       req_we;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_ready;

  logic       rq_rdy [2];
  logic       r_valid [2];
  logic [7:0] r_data [2];
  logic       b_en [2];
  logic       b_we [2];
  logic [3:0] b_addr [2];
  logic [7:0] b_wdata [2];
  logic [7:0] b_rdata [2];
  logic [2:0] pend_o [2];
  logic       id_o [2];

  logic [7:0] bmem0 [16];
  logic [7:0] bmem1 [16];
  logic [7:0] do0;
  logic [7:0] do1a;
  logic [7:0] do1b;

  int         lat [2] = '{1, 2};
  int         pend [2];
  int         qh [2];
  int         qt [2];
  logic [7:0] qd [2][64];
  int         qv [2][64];
  logic [7:0] mmem [2][16];
  int         cyc;
  bit         init_done;
  int         n_checks;
  int         n_fail;

  always #5 CLK = ~CLK;

  bram_port_requester #(.PIPELINED(0), .ADDR_WIDTH(4), .DATA_WIDTH(8), .RSP_DEPTH(4)) dut0 (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(rq_rdy[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(r_valid[0]), .rsp_ready(rsp_ready), .rsp_rdata(r_data[0]),
    .bram_en(b_en[0]), .bram_we(b_we[0]), .bram_addr(b_addr[0]),
    .bram_wdata(b_wdata[0]), .bram_rdata(b_rdata[0]),
    .rd_pending(pend_o[0]), .idle(id_o[0])
  );

  bram_port_requester #(.PIPELINED(1), .ADDR_WIDTH(4), .DATA_WIDTH(8), .RSP_DEPTH(4)) dut1 (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(rq_rdy[1]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(r_valid[1]), .rsp_ready(rsp_ready), .rsp_rdata(r_data[1]),
    .bram_en(b_en[1]), .bram_we(b_we[1]), .bram_addr(b_addr[1]),
    .bram_wdata(b_wdata[1]), .bram_rdata(b_rdata[1]),
    .rd_pending(pend_o[1]), .idle(id_o[1])
  );

  // BRAM2-style ports: write-through DO, optional extra output register that moves every cycle.
  always @(posedge CLK) begin
    if (b_en[0]) begin
      if (b_we[0]) bmem0[b_addr[0]] <= b_wdata[0];
      do0 <= b_we[0] ? b_wdata[0] : bmem0[b_addr[0]];
    end
  end

  always @(posedge CLK) begin
    if (b_en[1]) begin
      if (b_we[1]) bmem1[b_addr[1]] <= b_wdata[1];
      do1a <= b_we[1] ? b_wdata[1] : bmem1[b_addr[1]];
    end
    do1b <= do1a;
  end

  assign b_rdata[0] = do0;
  assign b_rdata[1] = do1b;

  function automatic bit expVisible(input int i);
    return (qt[i] > qh[i]) && (qv[i][qh[i] % 64] <= cyc);
  endfunction

  function automatic bit expReady(input int i);
    return RST_N && (pend[i] < 4);
  endfunction

  task automatic checkOne(input string tag, input int inst,
                          input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s[%0d] cycle=%0d observed=%0h expected=%0h", tag, inst, cyc, obs, exp);
    end
  endtask

  task automatic checkOutput();
    for (int i = 0; i < 2; i++) begin
      bit acc;
      bit ev;
      acc = req_valid && expReady(i);
      checkOne("req_ready", i, 32'(rq_rdy[i]), 32'(expReady(i)));
      checkOne("bram_en", i, 32'(b_en[i]), 32'(acc));
      if (acc) begin
        checkOne("bram_we", i, 32'(b_we[i]), 32'(req_we));
        checkOne("bram_addr", i, 32'(b_addr[i]), 32'(req_addr));
        checkOne("bram_wdata", i, 32'(b_wdata[i]), 32'(req_wdata));
      end
      if (init_done) begin
        ev = expVisible(i);
        checkOne("rsp_valid", i, 32'(r_valid[i]), 32'(ev));
        checkOne("rsp_rdata", i, 32'(r_data[i]), ev ? 32'(qd[i][qh[i] % 64]) : 32'h0);
        checkOne("rd_pending", i, 32'(pend_o[i]), 32'(pend[i]));
        checkOne("idle", i, 32'(id_o[i]), 32'(pend[i] == 0));
      end
    end
  endtask

  task automatic updateModel();
    for (int i = 0; i < 2; i++) begin
      bit acc;
      acc = req_valid && expReady(i);
      if (!RST_N) begin
        pend[i] = 0;
        qh[i]   = 0;
        qt[i]   = 0;
      end else begin
        if (expVisible(i) && rsp_ready) begin
          qh[i]++;
          pend[i]--;
        end
        if (acc && req_we)
          mmem[i][req_addr] = req_wdata;
        if (acc && !req_we) begin
          qd[i][qt[i] % 64] = mmem[i][req_addr];
          qv[i][qt[i] % 64] = cyc + lat[i] + 1;
          qt[i]++;
          pend[i]++;
        end
      end
    end
    if (!RST_N) init_done = 1'b1;
  endtask

  // One clock cycle: drive, check mid-cycle, advance the model across the edge.
  task automatic applyStimulus(input logic rst, input logic v, input logic we,
                               input logic [3:0] a, input logic [7:0] d, input logic rr);
    RST_N     = rst;
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    rsp_ready = rr;
    @(negedge CLK);
    checkOutput();
    updateModel();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    init_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0;
      qh[i]   = 0;
      qt[i]   = 0;
    end
    RST_N     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    @(posedge CLK);
    #1;

    $display("[TB] reset");
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);

    $display("[TB] preload addr k = 0x10+k");
    for (int a = 0; a < 16; a++)
      applyStimulus(1'b1, 1'b1, 1'b1, 4'(a), 8'(8'h10 + a), 1'b1);

    $display("[TB] write 0x5A to addr 3 then read it back");
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd3, 8'h5A, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd3, 8'h00, 1'b1);
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1);

    $display("[TB] back-to-back reads 0..7");
    for (int a = 0; a < 8; a++)
      applyStimulus(1'b1, 1'b1, 1'b0, 4'(a), 8'h00, 1'b1);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1);

    $display("[TB] stalled consumer, 6 reads offered");
    for (int a = 8; a < 14; a++)
      applyStimulus(1'b1, 1'b1, 1'b0, 4'(a), 8'h00, 1'b0);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd12, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd13, 8'h00, 1'b1);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1);

    $display("[TB] stale data: single read then idle");
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd1, 8'h00, 1'b1);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1);

    $display("[TB] accept and pop in the same cycle");
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd2, 8'h00, 1'b0);
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd4, 8'h00, 1'b1);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1);

    $display("[TB] reset right after a read accept");
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd5, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1);

    $display("[TB] random traffic");
    repeat (600) begin
      applyStimulus(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
                    8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0));
    end
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
